// File: rtl/prco_fetch_ctrl_if.sv
// Retire/debug inputs and fetch/status outputs of the prco fetch sequencer.
// The master side drives the core's inputs; the slave side is the sequencer.
interface prco_fetch_ctrl_if #(
  parameter int ADDR_W  = 16,
  parameter int BPSEL_W = 1
);
  logic               i_ce;
  logic               i_branch;
  logic [ADDR_W-1:0]  i_branch_target;
  logic               i_halt;
  logic               i_mode;
  logic               i_step;
  logic               i_resume;
  logic               i_bp_we;
  logic [BPSEL_W-1:0] i_bp_sel;
  logic               i_bp_en;
  logic [ADDR_W-1:0]  i_bp_addr;
  logic               q_ce;
  logic [ADDR_W-1:0]  q_pc;
  logic [2:0]         q_state;
  logic               q_halted;
  logic               q_bp_hit;
  logic [BPSEL_W-1:0] q_bp_id;
  logic [31:0]        q_retired;

  modport master (
    output i_ce, i_branch, i_branch_target, i_halt, i_mode, i_step, i_resume,
           i_bp_we, i_bp_sel, i_bp_en, i_bp_addr,
    input  q_ce, q_pc, q_state, q_halted, q_bp_hit, q_bp_id, q_retired
  );

  modport slave (
    input  i_ce, i_branch, i_branch_target, i_halt, i_mode, i_step, i_resume,
           i_bp_we, i_bp_sel, i_bp_en, i_bp_addr,
    output q_ce, q_pc, q_state, q_halted, q_bp_hit, q_bp_id, q_retired
  );
endinterface

// File: rtl/prco_fetch_ctrl.sv
// Program counter and fetch sequencer: one q_ce pulse per retired instruction,
// with branch flush, single-step, hardware breakpoints and halt.
module prco_fetch_ctrl #(
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                FLUSH_CYCLES = 3,
  parameter int                NUM_BP       = 2
) (
  input logic              i_clk,
  input logic              i_reset,
  prco_fetch_ctrl_if.slave bus
);
  localparam int BPSEL_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_FLUSH     = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_BP_STOP   = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  state_t             state_q, state_n;
  logic [ADDR_W-1:0]  pc_q, pc_n;
  logic               ce_q, ce_n;
  logic [3:0]         flush_cnt_q, flush_cnt_n;
  logic               step_mode_q, step_mode_n;
  logic [BPSEL_W-1:0] bp_id_q, bp_id_n;
  logic [31:0]        retired_q, retired_n;
  logic               pending_q;

  logic [NUM_BP-1:0]  bp_en_q;
  logic [ADDR_W-1:0]  bp_addr_q [NUM_BP];

  logic [ADDR_W-1:0]  seq_pc;
  logic [ADDR_W-1:0]  chk_addr;
  logic               bp_match;
  logic [BPSEL_W-1:0] bp_match_id;
  logic               do_issue;
  logic               issue_step;

  assign seq_pc = pc_q + ADDR_W'(1);

  // Address a fetch-issue this cycle would go to: the flushed target or the new NA.
  always_comb begin
    if (state_q == ST_FLUSH) begin
      chk_addr = pc_q;
    end else if (bus.i_branch) begin
      chk_addr = bus.i_branch_target;
    end else begin
      chk_addr = seq_pc;
    end
  end

  // Scanning downwards lets the lowest-numbered matching channel win.
  always_comb begin
    bp_match    = 1'b0;
    bp_match_id = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en_q[i] && (bp_addr_q[i] == chk_addr)) begin
        bp_match    = 1'b1;
        bp_match_id = BPSEL_W'(i);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bp_en_q   <= '0;
      bp_addr_q <= '{default: '0};
    end else if (bus.i_bp_we) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (bus.i_bp_sel == BPSEL_W'(i)) begin
          bp_en_q[i]   <= bus.i_bp_en;
          bp_addr_q[i] <= bus.i_bp_addr;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      ce_q        <= 1'b0;
      flush_cnt_q <= 4'd0;
      step_mode_q <= 1'b0;
      bp_id_q     <= '0;
      retired_q   <= 32'd0;
      pending_q   <= 1'b1;
    end else begin
      state_q     <= state_n;
      pc_q        <= pc_n;
      ce_q        <= ce_n;
      flush_cnt_q <= flush_cnt_n;
      step_mode_q <= step_mode_n;
      bp_id_q     <= bp_id_n;
      retired_q   <= retired_n;
      pending_q   <= 1'b0;
    end
  end

  // The start-up fetch after reset bypasses the breakpoint check entirely.
  always_comb begin
    state_n     = state_q;
    pc_n        = pc_q;
    ce_n        = 1'b0;
    flush_cnt_n = flush_cnt_q;
    step_mode_n = step_mode_q;
    bp_id_n     = bp_id_q;
    retired_n   = retired_q;
    do_issue    = 1'b0;
    issue_step  = 1'b0;
    if (pending_q) begin
      ce_n = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.i_ce) begin
            retired_n   = retired_q + 32'd1;
            step_mode_n = bus.i_mode;
            if (bus.i_halt) begin
              state_n = ST_HALT;
            end else if (bus.i_branch) begin
              pc_n = bus.i_branch_target;
              if (FLUSH_CYCLES == 0) begin
                do_issue   = 1'b1;
                issue_step = bus.i_mode;
              end else begin
                state_n     = ST_FLUSH;
                flush_cnt_n = 4'(FLUSH_CYCLES);
              end
            end else begin
              pc_n       = seq_pc;
              do_issue   = 1'b1;
              issue_step = bus.i_mode;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_q <= 4'd1) begin
            flush_cnt_n = 4'd0;
            do_issue    = 1'b1;
            issue_step  = step_mode_q;
          end else begin
            flush_cnt_n = flush_cnt_q - 4'd1;
          end
        end
        ST_STEP_WAIT: begin
          if (bus.i_step) begin
            ce_n    = 1'b1;
            state_n = ST_RUN;
          end
        end
        ST_BP_STOP: begin
          if (bus.i_resume) begin
            ce_n    = 1'b1;
            state_n = ST_RUN;
          end
        end
        ST_HALT: begin
          state_n = ST_HALT;
        end
        default: begin
          state_n = ST_RUN;
        end
      endcase

      if (do_issue) begin
        if (issue_step) begin
          state_n = ST_STEP_WAIT;
        end else if (bp_match) begin
          state_n = ST_BP_STOP;
          bp_id_n = bp_match_id;
        end else begin
          state_n = ST_RUN;
          ce_n    = 1'b1;
        end
      end
    end
  end

  assign bus.q_ce      = ce_q;
  assign bus.q_pc      = pc_q;
  assign bus.q_state   = state_q;
  assign bus.q_halted  = (state_q == ST_HALT);
  assign bus.q_bp_hit  = (state_q == ST_BP_STOP);
  assign bus.q_bp_id   = bp_id_q;
  assign bus.q_retired = retired_q;
endmodule

// File: tb/tb_prco_fetch_ctrl.sv
// Bench for prco_fetch_ctrl: a 16-bit, 3-cycle-flush, 2-channel instance plus a
// 4-bit, zero-flush, 1-channel instance for the wrap and immediate-branch cases.
module tb_prco_fetch_ctrl;
  localparam int FL = 3;

  logic        clk;
  logic        rst;
  int          total;
  int          bad;
  logic [15:0] m_pc;
  logic [31:0] m_ret;
  logic        m_en   [2];
  logic [15:0] m_addr [2];

  prco_fetch_ctrl_if #(.ADDR_W(16), .BPSEL_W(1)) bus ();
  prco_fetch_ctrl_if #(.ADDR_W(4),  .BPSEL_W(1)) sbus ();

  prco_fetch_ctrl #(
    .ADDR_W(16), .RESET_PC(16'h0000), .FLUSH_CYCLES(FL), .NUM_BP(2)
  ) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus)
  );

  prco_fetch_ctrl #(
    .ADDR_W(4), .RESET_PC(4'h0), .FLUSH_CYCLES(0), .NUM_BP(1)
  ) dut_small (
    .i_clk(clk), .i_reset(rst), .bus(sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.i_ce = 1'b0; bus.i_branch = 1'b0; bus.i_branch_target = '0; bus.i_halt = 1'b0;
    bus.i_mode = 1'b0; bus.i_step = 1'b0; bus.i_resume = 1'b0; bus.i_bp_we = 1'b0;
    bus.i_bp_sel = '0; bus.i_bp_en = 1'b0; bus.i_bp_addr = '0;
    sbus.i_ce = 1'b0; sbus.i_branch = 1'b0; sbus.i_branch_target = '0; sbus.i_halt = 1'b0;
    sbus.i_mode = 1'b0; sbus.i_step = 1'b0; sbus.i_resume = 1'b0; sbus.i_bp_we = 1'b0;
    sbus.i_bp_sel = '0; sbus.i_bp_en = 1'b0; sbus.i_bp_addr = '0;
  endtask

  task automatic model_reset();
    m_pc = 16'h0000;
    m_ret = 32'd0;
    for (int i = 0; i < 2; i++) begin
      m_en[i] = 1'b0;
      m_addr[i] = 16'h0000;
    end
  endtask

  task automatic pulse_ce(input logic br, input logic [15:0] tgt, input logic hl, input logic md);
    bus.i_ce = 1'b1; bus.i_branch = br; bus.i_branch_target = tgt; bus.i_halt = hl; bus.i_mode = md;
    tick();
    bus.i_ce = 1'b0; bus.i_branch = 1'b0; bus.i_halt = 1'b0; bus.i_mode = 1'b0;
  endtask

  task automatic pulse_resume();
    bus.i_resume = 1'b1;
    tick();
    bus.i_resume = 1'b0;
  endtask

  task automatic pulse_step();
    bus.i_step = 1'b1;
    tick();
    bus.i_step = 1'b0;
  endtask

  task automatic bp_write(input int sel, input logic en, input logic [15:0] a);
    bus.i_bp_we = 1'b1; bus.i_bp_sel = 1'(sel); bus.i_bp_en = en; bus.i_bp_addr = a;
    tick();
    bus.i_bp_we = 1'b0;
    m_en[sel] = en;
    m_addr[sel] = a;
  endtask

  // Reference: lowest enabled channel whose address equals a, or -1.
  function automatic int model_hit(input logic [15:0] a);
    for (int i = 0; i < 2; i++) begin
      if (m_en[i] && (m_addr[i] == a)) return i;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (bus.q_pc !== 16'h0000) begin bad++; $display("[TB] FAIL reset_pc got=%0h want=0", bus.q_pc); end
    total++; if (bus.q_ce !== 1'b0) begin bad++; $display("[TB] FAIL reset_ce got=%0b want=0", bus.q_ce); end
    total++; if (bus.q_state !== 3'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d want=0", bus.q_state); end
    total++; if (bus.q_halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_halted got=%0b want=0", bus.q_halted); end
    total++; if (bus.q_bp_hit !== 1'b0) begin bad++; $display("[TB] FAIL reset_bp_hit got=%0b want=0", bus.q_bp_hit); end
    total++; if (bus.q_bp_id !== 1'b0) begin bad++; $display("[TB] FAIL reset_bp_id got=%0d want=0", bus.q_bp_id); end
    total++; if (bus.q_retired !== 32'd0) begin bad++; $display("[TB] FAIL reset_retired got=%0d want=0", bus.q_retired); end
    rst = 1'b0;
    tick();
    total++; if (bus.q_ce !== 1'b1) begin bad++; $display("[TB] FAIL startup_ce got=%0b want=1", bus.q_ce); end
    total++; if (bus.q_pc !== 16'h0000) begin bad++; $display("[TB] FAIL startup_pc got=%0h want=0", bus.q_pc); end
    total++; if (sbus.q_ce !== 1'b1) begin bad++; $display("[TB] FAIL startup_small_ce got=%0b want=1", sbus.q_ce); end
    tick();
    total++; if (bus.q_ce !== 1'b0) begin bad++; $display("[TB] FAIL startup_single_pulse got=%0b want=0", bus.q_ce); end
    model_reset();
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 3; k++) begin
      pulse_ce(1'b0, 16'h0000, 1'b0, 1'b0);
      m_pc = m_pc + 16'd1;
      m_ret++;
      total++; if (bus.q_ce !== 1'b1) begin bad++; $display("[TB] FAIL seq_ce[%0d] got=%0b want=1", k, bus.q_ce); end
      total++; if (bus.q_pc !== m_pc) begin bad++; $display("[TB] FAIL seq_pc[%0d] got=%0h want=%0h", k, bus.q_pc, m_pc); end
      tick();
      total++; if (bus.q_ce !== 1'b0) begin bad++; $display("[TB] FAIL seq_pulse_width[%0d] got=%0b want=0", k, bus.q_ce); end
      tick();
      tick();
    end
    total++; if (bus.q_retired !== 32'd3) begin bad++; $display("[TB] FAIL seq_retired got=%0d want=3", bus.q_retired); end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_pc;
    // Channel 1 does not exist on the one-channel instance, so this write must be dropped.
    sbus.i_bp_we = 1'b1; sbus.i_bp_sel = 1'b1; sbus.i_bp_en = 1'b1; sbus.i_bp_addr = 4'h1;
    tick();
    sbus.i_bp_we = 1'b0;
    exp_pc = 4'h0;
    for (int k = 1; k <= 16; k++) begin
      sbus.i_ce = 1'b1;
      tick();
      sbus.i_ce = 1'b0;
      exp_pc = exp_pc + 4'd1;
      total++; if (sbus.q_ce !== 1'b1) begin bad++; $display("[TB] FAIL wrap_ce[%0d] got=%0b want=1", k, sbus.q_ce); end
      total++; if (sbus.q_pc !== exp_pc) begin bad++; $display("[TB] FAIL wrap_pc[%0d] got=%0h want=%0h", k, sbus.q_pc, exp_pc); end
    end
    total++; if (sbus.q_retired !== 32'd16) begin bad++; $display("[TB] FAIL wrap_retired got=%0d want=16", sbus.q_retired); end
    sbus.i_ce = 1'b1; sbus.i_branch = 1'b1; sbus.i_branch_target = 4'hA;
    tick();
    sbus.i_ce = 1'b0; sbus.i_branch = 1'b0;
    total++; if (sbus.q_ce !== 1'b1) begin bad++; $display("[TB] FAIL noflush_ce got=%0b want=1", sbus.q_ce); end
    total++; if (sbus.q_pc !== 4'hA) begin bad++; $display("[TB] FAIL noflush_pc got=%0h want=a", sbus.q_pc); end
    total++; if (sbus.q_state !== 3'd0) begin bad++; $display("[TB] FAIL noflush_state got=%0d want=0", sbus.q_state); end
  endtask

  task automatic test_branch_flush();
    pulse_ce(1'b1, 16'h0040, 1'b0, 1'b0);
    m_pc = 16'h0040;
    m_ret++;
    for (int j = 0; j < FL; j++) begin
      total++; if (bus.q_state !== 3'd1) begin bad++; $display("[TB] FAIL flush_state[%0d] got=%0d want=1", j, bus.q_state); end
      total++; if (bus.q_ce !== 1'b0) begin bad++; $display("[TB] FAIL flush_ce[%0d] got=%0b want=0", j, bus.q_ce); end
      total++; if (bus.q_pc !== 16'h0040) begin bad++; $display("[TB] FAIL flush_pc[%0d] got=%0h want=40", j, bus.q_pc); end
      if (j == 0) bus.i_ce = 1'b1;
      tick();
      bus.i_ce = 1'b0;
    end
    total++; if (bus.q_ce !== 1'b1) begin bad++; $display("[TB] FAIL flush_done_ce got=%0b want=1", bus.q_ce); end
    total++; if (bus.q_state !== 3'd0) begin bad++; $display("[TB] FAIL flush_done_state got=%0d want=0", bus.q_state); end
    total++; if (bus.q_retired !== m_ret) begin bad++; $display("[TB] FAIL flush_retired got=%0d want=%0d", bus.q_retired, m_ret); end
    tick();
    total++; if (bus.q_ce !== 1'b0) begin bad++; $display("[TB] FAIL flush_single_pulse got=%0b want=0", bus.q_ce); end
  endtask

  task automatic test_breakpoint();
    bp_write(1, 1'b1, 16'h0005);
    bp_write(0, 1'b1, 16'h0005);
    pulse_ce(1'b1, 16'h0000, 1'b0, 1'b0);
    m_pc = 16'h0000;
    m_ret++;
    repeat (FL) tick();
    total++; if (bus.q_ce !== 1'b1 || bus.q_pc !== 16'h0000) begin bad++; $display("[TB] FAIL bp_rewind got=%0b/%0h want=1/0", bus.q_ce, bus.q_pc); end
    for (int k = 1; k <= 4; k++) begin
      pulse_ce(1'b0, 16'h0000, 1'b0, 1'b0);
      m_ret++;
      total++; if (bus.q_ce !== 1'b1 || bus.q_pc !== 16'(k)) begin bad++; $display("[TB] FAIL bp_walk[%0d] got=%0b/%0h want=1/%0h", k, bus.q_ce, bus.q_pc, k); end
    end
    pulse_ce(1'b0, 16'h0000, 1'b0, 1'b0);
    m_pc = 16'h0005;
    m_ret++;
    total++; if (bus.q_bp_hit !== 1'b1) begin bad++; $display("[TB] FAIL bp_hit got=%0b want=1", bus.q_bp_hit); end
    total++; if (bus.q_bp_id !== 1'b0) begin bad++; $display("[TB] FAIL bp_id_lowest got=%0d want=0", bus.q_bp_id); end
    total++; if (bus.q_ce !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_ce got=%0b want=0", bus.q_ce); end
    total++; if (bus.q_state !== 3'd3) begin bad++; $display("[TB] FAIL bp_state got=%0d want=3", bus.q_state); end
    total++; if (bus.q_pc !== 16'h0005) begin bad++; $display("[TB] FAIL bp_pc got=%0h want=5", bus.q_pc); end
    pulse_ce(1'b0, 16'h0000, 1'b0, 1'b0);
    total++; if (bus.q_retired !== m_ret) begin bad++; $display("[TB] FAIL bp_ignore_ce got=%0d want=%0d", bus.q_retired, m_ret); end
    total++; if (bus.q_state !== 3'd3) begin bad++; $display("[TB] FAIL bp_still_stopped got=%0d want=3", bus.q_state); end
    pulse_resume();
    total++; if (bus.q_ce !== 1'b1 || bus.q_pc !== 16'h0005) begin bad++; $display("[TB] FAIL bp_resume got=%0b/%0h want=1/5", bus.q_ce, bus.q_pc); end
    total++; if (bus.q_bp_hit !== 1'b0) begin bad++; $display("[TB] FAIL bp_resume_hit got=%0b want=0", bus.q_bp_hit); end
    tick();
    total++; if (bus.q_state !== 3'd0 || bus.q_ce !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_retrigger got=%0d/%0b want=0/0", bus.q_state, bus.q_ce); end
    // Arm channel 0 at the very address being fetched: the old contents must decide.
    bus.i_ce = 1'b1; bus.i_bp_we = 1'b1; bus.i_bp_sel = 1'b0; bus.i_bp_en = 1'b1; bus.i_bp_addr = 16'h0006;
    tick();
    bus.i_ce = 1'b0; bus.i_bp_we = 1'b0;
    m_en[0] = 1'b1; m_addr[0] = 16'h0006; m_pc = 16'h0006; m_ret++;
    total++; if (bus.q_ce !== 1'b1 || bus.q_pc !== 16'h0006) begin bad++; $display("[TB] FAIL bp_old_value got=%0b/%0h want=1/6", bus.q_ce, bus.q_pc); end
    bp_write(0, 1'b0, 16'h0000);
    bp_write(1, 1'b1, 16'h0008);
    pulse_ce(1'b0, 16'h0000, 1'b0, 1'b0);
    m_ret++;
    total++; if (bus.q_ce !== 1'b1 || bus.q_pc !== 16'h0007) begin bad++; $display("[TB] FAIL bp_pass7 got=%0b/%0h want=1/7", bus.q_ce, bus.q_pc); end
    pulse_ce(1'b0, 16'h0000, 1'b0, 1'b0);
    m_ret++;
    m_pc = 16'h0008;
    total++; if (bus.q_bp_hit !== 1'b1 || bus.q_bp_id !== 1'b1) begin bad++; $display("[TB] FAIL bp_ch1 got=%0b/%0d want=1/1", bus.q_bp_hit, bus.q_bp_id); end
    pulse_resume();
    total++; if (bus.q_ce !== 1'b1 || bus.q_pc !== 16'h0008) begin bad++; $display("[TB] FAIL bp_ch1_resume got=%0b/%0h want=1/8", bus.q_ce, bus.q_pc); end
    bp_write(1, 1'b0, 16'h0000);
  endtask

  task automatic test_step();
    pulse_ce(1'b0, 16'h0000, 1'b0, 1'b1);
    m_pc = m_pc + 16'd1;
    m_ret++;
    total++; if (bus.q_state !== 3'd2) begin bad++; $display("[TB] FAIL step_wait_state got=%0d want=2", bus.q_state); end
    total++; if (bus.q_ce !== 1'b0) begin bad++; $display("[TB] FAIL step_wait_ce got=%0b want=0", bus.q_ce); end
    total++; if (bus.q_pc !== m_pc) begin bad++; $display("[TB] FAIL step_wait_pc got=%0h want=%0h", bus.q_pc, m_pc); end
    bus.i_ce = 1'b1;
    tick();
    bus.i_ce = 1'b0;
    repeat (4) tick();
    total++; if (bus.q_state !== 3'd2 || bus.q_ce !== 1'b0) begin bad++; $display("[TB] FAIL step_hold got=%0d/%0b want=2/0", bus.q_state, bus.q_ce); end
    total++; if (bus.q_retired !== m_ret) begin bad++; $display("[TB] FAIL step_ignore_ce got=%0d want=%0d", bus.q_retired, m_ret); end
    pulse_step();
    total++; if (bus.q_ce !== 1'b1 || bus.q_pc !== m_pc) begin bad++; $display("[TB] FAIL step_fetch got=%0b/%0h want=1/%0h", bus.q_ce, bus.q_pc, m_pc); end
    total++; if (bus.q_state !== 3'd0) begin bad++; $display("[TB] FAIL step_run got=%0d want=0", bus.q_state); end
    pulse_step();
    total++; if (bus.q_ce !== 1'b0 || bus.q_state !== 3'd0) begin bad++; $display("[TB] FAIL step_in_run got=%0b/%0d want=0/0", bus.q_ce, bus.q_state); end
    bp_write(0, 1'b1, m_pc + 16'd1);
    pulse_ce(1'b0, 16'h0000, 1'b0, 1'b1);
    m_pc = m_pc + 16'd1;
    m_ret++;
    total++; if (bus.q_state !== 3'd2) begin bad++; $display("[TB] FAIL step_over_bp_state got=%0d want=2", bus.q_state); end
    pulse_step();
    total++; if (bus.q_ce !== 1'b1 || bus.q_bp_hit !== 1'b0) begin bad++; $display("[TB] FAIL step_over_bp got=%0b/%0b want=1/0", bus.q_ce, bus.q_bp_hit); end
    bp_write(0, 1'b0, 16'h0000);
  endtask

  task automatic test_random();
    logic [15:0] tgt;
    logic [15:0] na;
    logic        br;
    int          r;
    int          exp_id;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        bp_write($urandom_range(0, 1), 1'($urandom_range(0, 1)), m_pc + 16'($urandom_range(1, 4)));
      end else begin
        br = (r <= 3);
        tgt = ($urandom_range(0, 1) == 1) ? 16'($urandom) : m_addr[$urandom_range(0, 1)];
        na = br ? tgt : m_pc + 16'd1;
        pulse_ce(br, tgt, 1'b0, 1'b0);
        m_pc = na;
        m_ret++;
        if (br) begin
          for (int j = 0; j < FL; j++) begin
            total++; if (bus.q_state !== 3'd1 || bus.q_ce !== 1'b0) begin bad++; $display("[TB] FAIL rnd_flush[%0d] got=%0d/%0b want=1/0", it, bus.q_state, bus.q_ce); end
            tick();
          end
        end
        exp_id = model_hit(na);
        if (exp_id < 0) begin
          total++; if (bus.q_ce !== 1'b1 || bus.q_pc !== na) begin bad++; $display("[TB] FAIL rnd_fetch[%0d] got=%0b/%0h want=1/%0h", it, bus.q_ce, bus.q_pc, na); end
        end else begin
          total++; if (bus.q_bp_hit !== 1'b1 || bus.q_ce !== 1'b0 || bus.q_pc !== na) begin bad++; $display("[TB] FAIL rnd_bp[%0d] got=%0b/%0b/%0h want=1/0/%0h", it, bus.q_bp_hit, bus.q_ce, bus.q_pc, na); end
          total++; if (bus.q_bp_id !== 1'(exp_id)) begin bad++; $display("[TB] FAIL rnd_bp_id[%0d] got=%0d want=%0d", it, bus.q_bp_id, exp_id); end
          pulse_resume();
          total++; if (bus.q_ce !== 1'b1 || bus.q_pc !== na) begin bad++; $display("[TB] FAIL rnd_resume[%0d] got=%0b/%0h want=1/%0h", it, bus.q_ce, bus.q_pc, na); end
        end
        repeat ($urandom_range(0, 2)) tick();
      end
    end
    total++; if (bus.q_retired !== m_ret) begin bad++; $display("[TB] FAIL rnd_retired got=%0d want=%0d", bus.q_retired, m_ret); end
  endtask

  task automatic test_reset_mid_flush();
    pulse_ce(1'b1, 16'h1234, 1'b0, 1'b0);
    tick();
    #2 rst = 1'b1;
    #1;
    total++; if (bus.q_state !== 3'd0 || bus.q_pc !== 16'h0000) begin bad++; $display("[TB] FAIL midflush_reset got=%0d/%0h want=0/0", bus.q_state, bus.q_pc); end
    total++; if (bus.q_retired !== 32'd0 || bus.q_ce !== 1'b0) begin bad++; $display("[TB] FAIL midflush_reset_cnt got=%0d/%0b want=0/0", bus.q_retired, bus.q_ce); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++; if (bus.q_ce !== 1'b1 || bus.q_pc !== 16'h0000) begin bad++; $display("[TB] FAIL midflush_startup got=%0b/%0h want=1/0", bus.q_ce, bus.q_pc); end
    model_reset();
  endtask

  task automatic test_halt();
    pulse_ce(1'b0, 16'h0000, 1'b0, 1'b0);
    m_pc = 16'h0001;
    m_ret++;
    total++; if (bus.q_ce !== 1'b1 || bus.q_pc !== m_pc) begin bad++; $display("[TB] FAIL halt_pre got=%0b/%0h want=1/1", bus.q_ce, bus.q_pc); end
    pulse_ce(1'b1, 16'hBEEF, 1'b1, 1'b0);
    m_ret++;
    total++; if (bus.q_halted !== 1'b1 || bus.q_state !== 3'd4) begin bad++; $display("[TB] FAIL halt_enter got=%0b/%0d want=1/4", bus.q_halted, bus.q_state); end
    total++; if (bus.q_pc !== m_pc || bus.q_ce !== 1'b0) begin bad++; $display("[TB] FAIL halt_pc got=%0h/%0b want=%0h/0", bus.q_pc, bus.q_ce, m_pc); end
    total++; if (bus.q_retired !== m_ret) begin bad++; $display("[TB] FAIL halt_counted got=%0d want=%0d", bus.q_retired, m_ret); end
    pulse_resume();
    total++; if (bus.q_ce !== 1'b0 || bus.q_halted !== 1'b1) begin bad++; $display("[TB] FAIL halt_resume got=%0b/%0b want=0/1", bus.q_ce, bus.q_halted); end
    pulse_step();
    total++; if (bus.q_ce !== 1'b0 || bus.q_halted !== 1'b1) begin bad++; $display("[TB] FAIL halt_step got=%0b/%0b want=0/1", bus.q_ce, bus.q_halted); end
    pulse_ce(1'b0, 16'h0000, 1'b0, 1'b0);
    total++; if (bus.q_ce !== 1'b0 || bus.q_retired !== m_ret) begin bad++; $display("[TB] FAIL halt_ce got=%0b/%0d want=0/%0d", bus.q_ce, bus.q_retired, m_ret); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.q_pc !== 16'h0000 || bus.q_halted !== 1'b0) begin bad++; $display("[TB] FAIL halt_reset got=%0h/%0b want=0/0", bus.q_pc, bus.q_halted); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    total++; if (bus.q_ce !== 1'b1 || bus.q_pc !== 16'h0000) begin bad++; $display("[TB] FAIL halt_startup got=%0b/%0h want=1/0", bus.q_ce, bus.q_pc); end
    model_reset();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    clear_inputs();
    model_reset();
    test_reset();
    test_sequential();
    test_wrap();
    test_branch_flush();
    test_breakpoint();
    test_step();
    test_random();
    test_reset_mid_flush();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prco_fetch_ctrl.md
Name: prco_fetch_ctrl

Overview:
Parametrised program-counter and fetch sequencer for the prco core. It replaces the ad-hoc PC/core_state logic with a clean state machine that has:
- configurable address width;
- configurable branch flush depth;
- NUM_BP hardware breakpoint channels;
- explicit run/step/halt/breakpoint states.

It sits between the pipeline retire signal (regs/ALU writeback) and the local-memory fetch port, issuing one fetch pulse per instruction.

Parameters:
ADDR_W, 16, PC/address width; PC arithmetic wraps modulo 2^ADDR_W
RESET_PC, 0, PC value loaded on reset
FLUSH_CYCLES, 3, idle cycles between branch acceptance and fetch of target (0..15)
NUM_BP, 2, number of breakpoint channels (1..8); BPSEL_W = max(1, clog2(NUM_BP))

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_ce  in  1  retire pulse: current instruction complete, next fetch may be issued
i_branch  in  1  qualified by i_ce: retiring instruction takes a branch
i_branch_target  in  ADDR_W  branch destination, sampled with i_ce&i_branch
i_halt  in  1  qualified by i_ce: retiring instruction is HALT
i_mode  in  1  0 = free run, 1 = single-step; sampled at i_ce
i_step  in  1  single-cycle step request
i_resume  in  1  single-cycle resume from breakpoint stop
i_bp_we  in  1  breakpoint register write strobe
i_bp_sel  in  BPSEL_W  breakpoint channel select
i_bp_en  in  1  enable bit written to the channel
i_bp_addr  in  ADDR_W  match address written to the channel
q_ce  out  1  one-cycle fetch pulse; q_pc valid in the same cycle
q_pc  out  ADDR_W  current fetch address
q_state  out  3  0 RUN, 1 FLUSH, 2 STEP_WAIT, 3 BP_STOP, 4 HALT
q_halted  out  1  high while in HALT
q_bp_hit  out  1  high while in BP_STOP
q_bp_id  out  BPSEL_W  lowest-numbered matching channel; valid while q_bp_hit
q_retired  out  32  count of accepted i_ce pulses; wraps

Behaviour:
- Reset (async):
  - q_pc=RESET_PC; state RUN; q_ce=0; q_halted=0; q_bp_hit=0; q_bp_id=0; q_retired=0.
  - Flush counter 0; all BP channels disabled, addresses 0; "pending" flag=1.
- Start-up: the first clock edge after reset deassertion gives q_ce=1 with q_pc=RESET_PC. pending clears. No BP check on this first fetch.
- q_ce is only ever a single-cycle pulse. Its next-fetch address NA is computed when i_ce is accepted.
- i_ce accepted only in RUN. On acceptance:
  - q_retired increments.
  - Priority: i_halt > i_branch > sequential.
  - NA = i_branch_target when branching, else q_pc+1 (wraps to 0 at 2^ADDR_W-1).
- Accepting i_ce in any other state: pulse is ignored and not counted.
- Halt: next state HALT; q_pc unchanged; no further q_ce. Exit is by reset only; i_step/i_resume ignored.
- Branch:
  - q_pc<=target on the next edge; state FLUSH, counter=FLUSH_CYCLES.
  - Counter decrements each cycle. The edge on which it reaches 0 triggers fetch-issue (see below).
  - FLUSH_CYCLES=0 means fetch-issue on the edge immediately after acceptance (same timing as sequential).
- Sequential: q_pc<=NA and fetch-issue on the edge immediately after acceptance.
- Fetch-issue (common to sequential and post-flush):
  - If i_mode (sampled at acceptance) = 1: state STEP_WAIT, no q_ce.
  - Else if any enabled BP address == q_pc(new): state BP_STOP; q_bp_hit=1; q_bp_id=lowest matching index; no q_ce.
  - Else: q_ce=1 one cycle; state RUN.
- STEP_WAIT: i_step → q_ce=1 on the next edge; state RUN; breakpoints are not checked for stepped fetches. i_step in any other state is ignored, not latched.
- BP_STOP: i_resume → q_ce=1 on the next edge for the same q_pc; q_bp_hit=0; state RUN. The resumed fetch is exempt from BP check, so there is no re-trigger. i_resume elsewhere is ignored.
- BP write: i_bp_we updates channel i_bp_sel; effective from the next edge. A match evaluated in the same cycle as the write uses the old value. i_bp_sel>=NUM_BP: write ignored.
- Reset mid-flush, mid-stop or mid-step: returns immediately to the reset state, including the start-up fetch.

Test Plan:
- Reset release, i_mode=0, i_ce pulsed every 4 cycles from cycle 2 -> q_ce at cycle 1 with q_pc=0; then q_ce one cycle after each i_ce with q_pc=1,2,3; q_retired=3.
- ADDR_W=4, q_pc=0xF, i_ce -> q_pc wraps to 0x0 with q_ce.
- FLUSH_CYCLES=3, i_ce&i_branch, target 0x0040 -> q_pc=0x0040 next edge, q_state=FLUSH for 3 cycles, then one q_ce; i_ce pulses during FLUSH are ignored and q_retired is unchanged.
- BP ch1 = 0x0005 enabled, ch0 = 0x0005 enabled, run from 0 -> at q_pc=5: q_bp_hit=1, q_bp_id=0, no q_ce; i_resume -> single q_ce at q_pc=5, no re-hit; next i_ce -> q_pc=6.
- i_mode=1: i_ce -> STEP_WAIT, no q_ce; i_step 5 cycles later -> q_ce next edge; i_step while in RUN -> no effect.
- i_ce&i_halt&i_branch -> HALT (halt wins), q_halted=1, q_pc unchanged; i_resume/i_step produce no q_ce; async i_reset mid-HALT -> q_pc=RESET_PC, start-up q_ce after release.
